micro_sequencer: RTL and testbench

- Microprogram counter (uPC) register and microcode store for the multicycle MIPS microprogrammed control unit.
- Latches the 5-bit next micro-address produced by the next-address mux each cycle and decodes the stored micro-instruction into datapath control signals.
- Drives the mux inputs `next_addr_select`, `adder_plus_1` and `WriteBack`, closing the sequencing loop.
- Dispatch tables are separate ROMs and are outside this block.

---
 rtl/micro_sequencer_pkg.sv | 46 ++++
 rtl/micro_sequencer_rom.sv | 74 +++++++
 rtl/micro_sequencer.sv | 36 +++
 tb/tb_micro_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// micro_pkg: address, select and control-word definitions shared by the micro-sequencer and its ROM
package micro_pkg;
  localparam int UADDR_W = 5;
  localparam int CTRL_W = 18;
  localparam int CNT_W = 16;
  localparam logic [UADDR_W-1:0] WB_ADDR = 5'd7;
  localparam logic [UADDR_W-1:0] EXC_ADDR = 5'd30;
  localparam logic [UADDR_W-1:0] S_FETCH = 5'd0;
  localparam logic [UADDR_W-1:0] S_DECODE = 5'd1;
  localparam logic [UADDR_W-1:0] S_MEMADDR = 5'd2;
  localparam logic [UADDR_W-1:0] S_MEMRD = 5'd3;
  localparam logic [UADDR_W-1:0] S_MEMWB = 5'd4;
  localparam logic [UADDR_W-1:0] S_MEMWR = 5'd5;
  localparam logic [UADDR_W-1:0] S_REXEC = 5'd6;
  localparam logic [UADDR_W-1:0] S_RWB = 5'd7;
  localparam logic [UADDR_W-1:0] S_BEQ = 5'd8;
  localparam logic [UADDR_W-1:0] S_JUMP = 5'd9;
  localparam logic [UADDR_W-1:0] S_ADDIEXEC = 5'd10;
  localparam logic [UADDR_W-1:0] S_ADDIWB = 5'd11;
  localparam logic [UADDR_W-1:0] S_EXC = EXC_ADDR;
  typedef enum logic [2:0] {
    SEL_ZERO  = 3'b000,
    SEL_DISP1 = 3'b001,
    SEL_DISP2 = 3'b010,
    SEL_DISP3 = 3'b011,
    SEL_PLUS1 = 3'b100,
    SEL_WB    = 3'b101,
    SEL_EXC   = 3'b110
  } sel_e;
  localparam int PC_WRITE = 0;
  localparam int PC_WRITE_COND = 1;
  localparam int IORD = 2;
  localparam int MEM_READ = 3;
  localparam int MEM_WRITE = 4;
  localparam int IR_WRITE = 5;
  localparam int MEM_TO_REG = 6;
  localparam int REG_DST = 7;
  localparam int REG_WRITE = 8;
  localparam int ALU_SRC_A = 9;
  localparam int ALU_SRC_B = 10;
  localparam int ALU_OP = 12;
  localparam int PC_SOURCE = 14;
  localparam int EPC_WRITE = 16;
  localparam int CAUSE_WRITE = 17;
  localparam logic [CTRL_W-1:0] HOLD_MASK = CTRL_W'((1 << IR_WRITE) | (1 << PC_WRITE) | (1 << REG_WRITE));
endpackage

// File: rtl/micro_sequencer_rom.sv
// microcode_rom: combinational microcode store mapping a micro-address to its sequencing select and control word
module microcode_rom
  import micro_pkg::*;
(
  input  logic [UADDR_W-1:0] upc,
  output logic [2:0]         seq,
  output logic [CTRL_W-1:0]  ctrl
);
  always_comb begin
    seq = SEL_ZERO;
    ctrl = '0;
    case (upc)
      S_FETCH: begin
        seq = SEL_PLUS1;
        ctrl[MEM_READ] = 1'b1;
        ctrl[IR_WRITE] = 1'b1;
        ctrl[PC_WRITE] = 1'b1;
        ctrl[ALU_SRC_B +: 2] = 2'b01;
      end
      S_DECODE: begin
        seq = SEL_DISP1;
        ctrl[ALU_SRC_B +: 2] = 2'b11;
      end
      S_MEMADDR: begin
        seq = SEL_DISP2;
        ctrl[ALU_SRC_A] = 1'b1;
        ctrl[ALU_SRC_B +: 2] = 2'b10;
      end
      S_MEMRD: begin
        seq = SEL_PLUS1;
        ctrl[MEM_READ] = 1'b1;
        ctrl[IORD] = 1'b1;
      end
      S_MEMWB: begin
        ctrl[REG_WRITE] = 1'b1;
        ctrl[MEM_TO_REG] = 1'b1;
      end
      S_MEMWR: begin
        ctrl[MEM_WRITE] = 1'b1;
        ctrl[IORD] = 1'b1;
      end
      S_REXEC: begin
        seq = SEL_WB;
        ctrl[ALU_SRC_A] = 1'b1;
        ctrl[ALU_OP +: 2] = 2'b10;
      end
      S_RWB: begin
        ctrl[REG_WRITE] = 1'b1;
        ctrl[REG_DST] = 1'b1;
      end
      S_BEQ: begin
        ctrl[ALU_SRC_A] = 1'b1;
        ctrl[ALU_OP +: 2] = 2'b01;
        ctrl[PC_WRITE_COND] = 1'b1;
        ctrl[PC_SOURCE +: 2] = 2'b01;
      end
      S_JUMP: begin
        ctrl[PC_WRITE] = 1'b1;
        ctrl[PC_SOURCE +: 2] = 2'b10;
      end
      S_ADDIEXEC: begin
        seq = SEL_DISP3;
        ctrl[ALU_SRC_A] = 1'b1;
        ctrl[ALU_SRC_B +: 2] = 2'b10;
      end
      S_ADDIWB: ctrl[REG_WRITE] = 1'b1;
      S_EXC: begin
        ctrl[EPC_WRITE] = 1'b1;
        ctrl[CAUSE_WRITE] = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: uPC register with memory-wait hold, overflow override and retired-instruction counter
module micro_sequencer
  import micro_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [UADDR_W-1:0] current_address,
  input  logic               mem_ready,
  input  logic               overflow,
  output logic [UADDR_W-1:0] upc,
  output logic [UADDR_W-1:0] adder_plus_1,
  output logic [UADDR_W-1:0] WriteBack,
  output logic [2:0]         next_addr_select,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               upc_hold,
  output logic [CNT_W-1:0]   instr_count
);
  logic [2:0] rom_seq;
  logic [CTRL_W-1:0] rom_ctrl;
  microcode_rom u_rom (.upc(upc), .seq(rom_seq), .ctrl(rom_ctrl));
  always_comb begin
    upc_hold = (upc == S_FETCH || upc == S_MEMRD || upc == S_MEMWR) && !mem_ready;
    next_addr_select = ((upc == S_REXEC || upc == S_ADDIEXEC) && overflow) ? SEL_EXC : rom_seq;
    ctrl = upc_hold ? rom_ctrl & ~HOLD_MASK : rom_ctrl;
    adder_plus_1 = upc + 1'b1;
    WriteBack = WB_ADDR;
  end
  always_ff @(posedge clk)
    if (reset) begin
      upc <= '0;
      instr_count <= '0;
    end else if (!upc_hold) begin
      upc <= current_address;
      if (upc != S_FETCH && next_addr_select == SEL_ZERO) instr_count <= instr_count + 1'b1;
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench driving micro_sequencer through a next-address mux model
module tb_micro_sequencer;
  import micro_pkg::*;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b1, overflow = 1'b0;
  logic [UADDR_W-1:0] current_address, upc, adder_plus_1, write_back, mux;
  logic [2:0] next_addr_select;
  logic [CTRL_W-1:0] ctrl;
  logic upc_hold;
  logic [CNT_W-1:0] instr_count;
  logic [5:0] op = 6'd35;
  logic force_en = 1'b0;
  logic [UADDR_W-1:0] force_addr = '0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [5:0] ops [6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
  int vectors = 0, miscompares = 0, seen_111 = 0;
  typedef struct {
    logic [4:0]  upc;
    logic [2:0]  sel;
    logic [15:0] cnt;
    logic [17:0] ctrl;
    logic        hold;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  micro_sequencer dut (
    .clk(clk), .reset(reset), .current_address(current_address), .mem_ready(mem_ready),
    .overflow(overflow), .upc(upc), .adder_plus_1(adder_plus_1), .WriteBack(write_back),
    .next_addr_select(next_addr_select), .ctrl(ctrl), .upc_hold(upc_hold), .instr_count(instr_count)
  );
  function automatic logic [4:0] disp1(input logic [5:0] o);
    case (o)
      6'd35, 6'd43: return 5'd2;
      6'd0: return 5'd6;
      6'd4: return 5'd8;
      6'd2: return 5'd9;
      6'd8: return 5'd10;
      default: return 5'd30;
    endcase
  endfunction
  always_comb begin
    case (next_addr_select)
      3'b001: mux = disp1(op);
      3'b010: mux = op == 6'd43 ? 5'd5 : 5'd3;
      3'b011: mux = 5'd11;
      3'b100: mux = adder_plus_1;
      3'b101: mux = write_back;
      3'b110: mux = 5'd30;
      default: mux = 5'd0;
    endcase
    current_address = force_en ? force_addr : mux;
  end
  always @(negedge clk) if (next_addr_select == 3'b111) seen_111++;
  function automatic logic [17:0] cw(input logic [4:0] u);
    case (u)
      5'd0: return 18'h00429;
      5'd1: return 18'h00C00;
      5'd2: return 18'h00A00;
      5'd3: return 18'h0000C;
      5'd4: return 18'h00140;
      5'd5: return 18'h00014;
      5'd6: return 18'h02200;
      5'd7: return 18'h00180;
      5'd8: return 18'h05202;
      5'd9: return 18'h08001;
      5'd10: return 18'h00A00;
      5'd11: return 18'h00100;
      5'd30: return 18'h30000;
      default: return 18'h0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [4:0] u, input logic [2:0] s, input logic h);
    exp_t e;
    e.upc = u;
    e.sel = s;
    e.cnt = exp_cnt;
    e.ctrl = h ? cw(u) & ~18'h00121 : cw(u);
    e.hold = h;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk("upc", 32'(upc), 32'(e.upc));
      chk("sel", 32'(next_addr_select), 32'(e.sel));
      chk("cnt", 32'(instr_count), 32'(e.cnt));
      chk("ctrl", 32'(ctrl), 32'(e.ctrl));
      chk("hold", 32'(upc_hold), 32'(e.hold));
    end
  endtask
  task automatic back_to_fetch();
    exp_cnt++;
    push(5'd0, 3'b100, 1'b0);
    drain();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_upc", 32'(upc), 0);
    chk("rst_cnt", 32'(instr_count), 0);
    chk("rst_sel", 32'(next_addr_select), 32'b100);
    chk("rst_plus1", 32'(adder_plus_1), 1);
    chk("rst_ctrl", 32'(ctrl), 32'(cw(5'd0)));
    chk("writeback", 32'(write_back), 7);
    op = 6'd35;
    push(5'd1, 3'b001, 0); push(5'd2, 3'b010, 0); push(5'd3, 3'b100, 0); push(5'd4, 3'b000, 0);
    drain(); back_to_fetch();
    op = 6'd0;
    push(5'd1, 3'b001, 0); push(5'd6, 3'b101, 0); push(5'd7, 3'b000, 0);
    drain(); back_to_fetch();
    overflow = 1'b1;
    push(5'd1, 3'b001, 0); push(5'd6, 3'b110, 0); push(5'd30, 3'b000, 0);
    drain(); back_to_fetch();
    op = 6'd8;
    push(5'd1, 3'b001, 0); push(5'd10, 3'b110, 0); push(5'd30, 3'b000, 0);
    drain(); back_to_fetch();
    overflow = 1'b0;
    push(5'd1, 3'b001, 0); push(5'd10, 3'b011, 0); push(5'd11, 3'b000, 0);
    drain(); back_to_fetch();
    op = 6'd4;
    push(5'd1, 3'b001, 0); push(5'd8, 3'b000, 0);
    drain(); back_to_fetch();
    mem_ready = 1'b0;
    #1;
    chk("fetch_hold", 32'(upc_hold), 1);
    chk("fetch_hold_ctrl", 32'(ctrl), 32'h408);
    repeat (3) push(5'd0, 3'b100, 1);
    drain();
    mem_ready = 1'b1;
    op = 6'd2;
    #1;
    chk("fetch_release", 32'(upc_hold), 0);
    push(5'd1, 3'b001, 0); push(5'd9, 3'b000, 0);
    drain(); back_to_fetch();
    op = 6'd43;
    push(5'd1, 3'b001, 0); push(5'd2, 3'b010, 0); push(5'd5, 3'b000, 0);
    drain();
    mem_ready = 1'b0;
    repeat (2) push(5'd5, 3'b000, 1);
    drain();
    mem_ready = 1'b1;
    back_to_fetch();
    force_en = 1'b1;
    force_addr = 5'd31;
    push(5'd31, 3'b000, 0);
    drain();
    chk("wrap_plus1", 32'(adder_plus_1), 0);
    force_en = 1'b0;
    back_to_fetch();
    op = 6'd35;
    push(5'd1, 3'b001, 0); push(5'd2, 3'b010, 0); push(5'd3, 3'b100, 0);
    drain();
    mem_ready = 1'b0;
    push(5'd3, 3'b100, 1);
    drain();
    reset = 1'b1;
    exp_cnt = '0;
    push(5'd0, 3'b100, 1);
    drain();
    reset = 1'b0;
    mem_ready = 1'b1;
    force_en = 1'b1;
    force_addr = 5'd12;
    repeat (65536) @(negedge clk);
    chk("cnt_max", 32'(instr_count), 32'hFFFF);
    chk("illegal_upc", 32'(upc), 12);
    chk("illegal_sel", 32'(next_addr_select), 0);
    chk("illegal_ctrl", 32'(ctrl), 0);
    @(negedge clk);
    chk("cnt_wrap", 32'(instr_count), 0);
    force_en = 1'b0;
    @(negedge clk);
    chk("illegal_exit_upc", 32'(upc), 0);
    chk("illegal_exit_cnt", 32'(instr_count), 1);
    repeat (10000) begin
      @(negedge clk);
      op = $urandom_range(0, 7) == 0 ? 6'($urandom) : ops[$urandom_range(0, 5)];
      mem_ready = $urandom_range(0, 3) != 0;
      overflow = 1'($urandom_range(0, 1));
    end
    chk("sel_111_seen", 32'(seen_111), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
